// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg7_pkg;

    // Scanner states; BLANK is the one-cycle load of the all-dark word.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DWELL,
        BLANK
    } state_e;

    // All segments off (active-low drive).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Shift word: 7 segments + colon + one anode per digit.
    function automatic int sr_width(input int num_digits);
        return 8 + num_digits;
    endfunction

    // Width of a counter that runs 0..count-1. Never narrower than 1 bit.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-low 7-segment pattern (bit order g,f,e,d,c,b,a).
// Latency: combinational.
// Backpressure: none.
// Optional macro SEG7_SCAN_HEX_EN: values 10-15 show A,b,C,d,E,F; otherwise blank.
// Ports: value_i - 4-bit value; seg_o - segment pattern, 0 = segment lit.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (value_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
`ifdef SEG7_SCAN_HEX_EN
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
`endif
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_shifter.sv
// Multiplexed common-anode 7-segment scanner driving an external SIPO shift register chain.
// Latency: one word per 1 + 2*CLK_DIV*SR_W + CLK_DIV + DWELL_CYCLES clk cycles; frame = NUM_DIGITS words.
// Backpressure: none; enable_i is sampled only in IDLE and at dwell exit, so words are never truncated.
// Optional macro SEG7_SCAN_HEX_EN (in seg7_hex_decode): hex letters for digit values 10-15.
// Ports: clk/rst_n (async active-low); enable_i scan enable; digits_i nibble k = digit k;
//        colon_i colon request; sr_data_o/sr_clk_o/sr_latch_o to the register chain;
//        frame_done_o pulse at last digit's dwell exit; busy_o high when not IDLE.
module seg7_scan_shifter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int COLON_DIGIT  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    colon_i,
    output logic                    sr_data_o,
    output logic                    sr_clk_o,
    output logic                    sr_latch_o,
    output logic                    frame_done_o,
    output logic                    busy_o
);

    localparam int SR_W  = sr_width(NUM_DIGITS);
    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(SR_W);
    localparam int DW_W  = cnt_width(DWELL_CYCLES);
    localparam int IDX_W = cnt_width(NUM_DIGITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_W - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_COL  = IDX_W'(COLON_DIGIT);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DW_W-1:0]         dwell_q, dwell_d;
    logic [SR_W-1:0]         word_q, word_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic                    snap_col_q, snap_col_d;
    logic                    blank_q, blank_d;
    logic                    sr_clk_q, sr_clk_d;
    logic                    latch_q, latch_d;

    // Digit 0 reads the live inputs (the snapshot is being taken in the same
    // cycle); later digits read the frozen snapshot so a frame never tears.
    logic [4*NUM_DIGITS-1:0] dig_src;
    logic                    col_src;
    logic [3:0]              nibble;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   anode;
    logic [SR_W-1:0]         load_word;

    always_comb begin
        dig_src      = (idx_q == '0) ? digits_i : snap_q;
        col_src      = (idx_q == '0) ? colon_i : snap_col_q;
        nibble       = dig_src[{idx_q, 2'b00} +: 4];
        anode        = '0;
        anode[idx_q] = 1'b1;
        load_word    = {anode, ~((idx_q == IDX_COL) & col_src), seg};
    end

    seg7_hex_decode u_dec (
        .value_i (nibble),
        .seg_o   (seg)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        div_d      = div_q;
        bit_d      = bit_q;
        dwell_d    = dwell_q;
        word_d     = word_q;
        snap_d     = snap_q;
        snap_col_d = snap_col_q;
        blank_d    = blank_q;
        sr_clk_d   = sr_clk_q;
        latch_d    = latch_q;
        case (state_q)
            IDLE: begin
                if (enable_i) state_d = LOAD;
            end
            LOAD: begin
                if (idx_q == '0) begin
                    snap_d     = digits_i;
                    snap_col_d = colon_i;
                end
                word_d   = load_word;
                blank_d  = 1'b0;
                div_d    = '0;
                bit_d    = '0;
                sr_clk_d = 1'b0;
                state_d  = SHIFT;
            end
            BLANK: begin
                word_d   = {{NUM_DIGITS{1'b0}}, 1'b1, SEG_BLANK};
                blank_d  = 1'b1;
                div_d    = '0;
                bit_d    = '0;
                sr_clk_d = 1'b0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sr_clk_q) begin
                        sr_clk_d = 1'b1;
                    end else begin
                        // Falling shift clock ends the bit: present the next
                        // bit on the same edge. The word drains to zero, so
                        // sr_data_o idles low outside SHIFT.
                        sr_clk_d = 1'b0;
                        word_d   = {word_q[SR_W-2:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            latch_d = 1'b1;
                            state_d = LATCH;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    latch_d = 1'b0;
                    dwell_d = '0;
                    if (blank_q) begin
                        blank_d = 1'b0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = DWELL;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DWELL: begin
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    state_d = enable_i ? LOAD : BLANK;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            dwell_q    <= '0;
            word_q     <= '0;
            snap_q     <= '0;
            snap_col_q <= 1'b0;
            blank_q    <= 1'b0;
            sr_clk_q   <= 1'b0;
            latch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            dwell_q    <= dwell_d;
            word_q     <= word_d;
            snap_q     <= snap_d;
            snap_col_q <= snap_col_d;
            blank_q    <= blank_d;
            sr_clk_q   <= sr_clk_d;
            latch_q    <= latch_d;
        end
    end

    // Pin-facing strobes come straight from flops to keep them glitch-free.
    assign sr_data_o    = word_q[SR_W-1];
    assign sr_clk_o     = sr_clk_q;
    assign sr_latch_o   = latch_q;
    assign frame_done_o = (state_q == DWELL) && (dwell_q == DW_LAST) && (idx_q == IDX_LAST);
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_scan_shifter.sv
// Self-checking bench for seg7_scan_shifter: timing model per cycle plus an
// external shift-register/latch model capturing the words seen on the pins.
module tb_seg7_scan_shifter;

    localparam int ND        = 4;
    localparam int CD        = 2;
    localparam int DW        = 16;
    localparam int CDIG      = 1;
    localparam int SRW       = 8 + ND;
    localparam int SH        = 2 * CD * SRW;
    localparam int WORD_LEN  = 1 + SH + CD + DW;
    localparam int BLANK_LEN = 1 + SH + CD;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable_i = 1'b0;
    logic [4*ND-1:0] digits_i = '0;
    logic            colon_i = 1'b0;
    logic            sr_data_o, sr_clk_o, sr_latch_o, frame_done_o, busy_o;

    always #5 clk = ~clk;

    seg7_scan_shifter #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (CD),
        .DWELL_CYCLES (DW),
        .COLON_DIGIT  (CDIG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .digits_i     (digits_i),
        .colon_i      (colon_i),
        .sr_data_o    (sr_data_o),
        .sr_clk_o     (sr_clk_o),
        .sr_latch_o   (sr_latch_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lit segments (active high, bit0 = a) for 0-F; the pins drive the inverse.
    logic [6:0] seg_on [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] ref_seg(input int v);
`ifdef SEG7_SCAN_HEX_EN
        return ~seg_on[v];
`else
        if (v >= 10) return 7'h7F;
        return ~seg_on[v];
`endif
    endfunction

    function automatic logic [11:0] ref_word(input int ix, input int v, input bit col, input bit blank);
        logic [11:0] w;
        w = '0;
        if (blank) begin
            w[7:0] = 8'hFF;
        end else begin
            w[6:0]  = ref_seg(v);
            w[7]    = !(ix == CDIG && col);
            w[8+ix] = 1'b1;
        end
        return w;
    endfunction

    // Behavioural model: position (m_o) inside the current word, counted in clk cycles.
    bit          m_active, m_blank;
    int          m_o, m_idx;
    logic [15:0] m_snap;
    bit          m_scol;
    logic [11:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_blank  <= 1'b0;
            m_o      <= 0;
            m_idx    <= 0;
            m_snap   <= '0;
            m_scol   <= 1'b0;
            m_word   <= '0;
        end else begin : step
            bit          a, bl, sc;
            int          o, ix;
            logic [15:0] sn;
            logic [11:0] w;
            a = m_active; bl = m_blank; o = m_o; ix = m_idx;
            sn = m_snap; sc = m_scol; w = m_word;
            if (!a) begin
                if (enable_i) begin
                    a = 1'b1; bl = 1'b0; o = 0;
                end
            end else begin
                if (o == 0) begin
                    if (bl) begin
                        w = ref_word(0, 0, 1'b0, 1'b1);
                    end else begin
                        if (ix == 0) begin
                            sn = digits_i;
                            sc = colon_i;
                        end
                        w = ref_word(ix, int'(sn[4*ix +: 4]), sc, 1'b0);
                    end
                end
                o++;
                if (bl && o == BLANK_LEN) begin
                    a = 1'b0; bl = 1'b0; ix = 0; o = 0;
                end else if (!bl && o == WORD_LEN) begin
                    ix = (ix + 1) % ND; o = 0; bl = !enable_i;
                end
            end
            m_active <= a; m_blank <= bl; m_o <= o; m_idx <= ix;
            m_snap <= sn; m_scol <= sc; m_word <= w;
        end
    end

    int cyc = 0;
    int fd_cyc [$];
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin : cmp
            bit e_clk, e_data, e_latch, e_fd;
            int b, r;
            e_clk = 0; e_data = 0; e_latch = 0; e_fd = 0;
            if (m_active && m_o >= 1 && m_o <= SH) begin
                b = (m_o - 1) / (2 * CD);
                r = (m_o - 1) % (2 * CD);
                e_clk  = (r >= CD);
                e_data = m_word[SRW-1-b];
            end
            e_latch = m_active && m_o > SH && m_o <= SH + CD;
            e_fd    = m_active && !m_blank && m_o == WORD_LEN - 1 && m_idx == ND - 1;
            check("busy", int'(busy_o), int'(m_active));
            check("sr_clk", int'(sr_clk_o), int'(e_clk));
            check("sr_data", int'(sr_data_o), int'(e_data));
            check("sr_latch", int'(sr_latch_o), int'(e_latch));
            check("frame_done", int'(frame_done_o), int'(e_fd));
            if (frame_done_o) fd_cyc.push_back(cyc);
        end
    end

    // External 74HC595-style chain: shift on sr_clk rise, capture on latch rise.
    logic [11:0] ext_sh = '0;
    logic [11:0] lat_q [$];
    int          clk_edges = 0;
    always @(posedge sr_clk_o) begin
        ext_sh    <= {ext_sh[10:0], sr_data_o};
        clk_edges <= clk_edges + 1;
    end
    always @(posedge sr_latch_o) lat_q.push_back(ext_sh);

    task automatic wait_lat(input int n, input string nm);
        int k = 0;
        while (lat_q.size() < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check(nm, int'(lat_q.size() >= n), 1);
    endtask

    task automatic wait_model(input int ix, input int o, input string nm);
        int k = 0;
        while (!(m_active && !m_blank && m_idx == ix && m_o == o) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        check(nm, int'(m_active && !m_blank && m_idx == ix && m_o == o), 1);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_data"}, int'(sr_data_o), 0);
        check({nm, "_clk"}, int'(sr_clk_o), 0);
        check({nm, "_latch"}, int'(sr_latch_o), 0);
        check({nm, "_fd"}, int'(frame_done_o), 0);
        check({nm, "_busy"}, int'(busy_o), 0);
    endtask

    logic [11:0] exp_f;
    int          n;

    initial begin
        // Reset and idle with enable low
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("idle_busy", int'(busy_o), 0);
        check("idle_clk_edges", clk_edges, 0);

        // Basic frame
        digits_i = 16'h4321; colon_i = 1'b1; enable_i = 1'b1;
        wait_lat(2, "basic_lat_timeout");
        if (lat_q.size() >= 2) begin
            check("word_digit0", int'(lat_q[0]), 12'h1F9);
            check("word_digit1", int'(lat_q[1]), 12'h224);
        end
        begin
            int k = 0;
            while (fd_cyc.size() < 2 && k < 1000) begin @(posedge clk); #1; k++; end
        end
        check("fd_seen", int'(fd_cyc.size() >= 2), 1);
        if (fd_cyc.size() >= 2) check("frame_period", fd_cyc[1] - fd_cyc[0], 268);

        // Snapshot: change during digit 2
        wait_model(2, 5, "snap_wait");
        n = lat_q.size();
        digits_i = 16'h9999;
        wait_lat(n + 3, "snap_lat_timeout");
        if (lat_q.size() >= n + 3) begin
            check("snap_digit2", int'(lat_q[n]), 12'h4B0);
            check("snap_digit3", int'(lat_q[n+1]), 12'h899);
            check("snap_next0", int'(lat_q[n+2]), 12'h190);
        end

        // Enable drop during digit 1 dwell
        wait_model(1, SH + CD + 3, "drop_wait");
        n = lat_q.size();
        enable_i = 1'b0;
        begin
            int k = 0;
            while (busy_o && k < 300) begin @(posedge clk); #1; k++; end
        end
        check("drop_busy_low", int'(busy_o), 0);
        check("drop_one_word", lat_q.size(), n + 1);
        if (lat_q.size() > n) check("blank_word", int'(lat_q[n]), 12'h0FF);
        enable_i = 1'b1;
        wait_lat(n + 2, "restart_lat_timeout");
        if (lat_q.size() >= n + 2) check("restart_digit0", int'(lat_q[n+1]), 12'h190);

        // Async reset after 5 bits of digit 1
        wait_model(1, 1 + 5 * 2 * CD, "rst_wait");
        n = lat_q.size();
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_rst");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rst_no_latch", lat_q.size(), n);
        wait_lat(n + 1, "rst_lat_timeout");
        if (lat_q.size() > n) check("rst_restart0", int'(lat_q[n]), 12'h190);

        // Hex value F on digit 0, colon off
        digits_i = 16'h000F; colon_i = 1'b0;
        wait_model(3, 5, "hex_wait");
        n = lat_q.size();
        wait_lat(n + 3, "hex_lat_timeout");
`ifdef SEG7_SCAN_HEX_EN
        exp_f = 12'h18E;
`else
        exp_f = 12'h1FF;
`endif
        if (lat_q.size() >= n + 3) begin
            check("hex_f", int'(lat_q[n+1]), int'(exp_f));
            check("zero_no_colon", int'(lat_q[n+2]), 12'h2C0);
        end

        // Randomized traffic against the per-cycle model
        for (int r = 0; r < 10; r++) begin
            digits_i = 16'($urandom);
            colon_i  = 1'($urandom_range(0, 1));
            enable_i = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(20, 300)) @(posedge clk);
            #1;
        end
        enable_i = 1'b1;
        repeat (300) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
